// File: rtl/zx_pkg.sv
// Shared constants for the ZX Spectrum pager: I/O port decode patterns,
// fixed RAM banks and the +3 special all-RAM bank table.
package zx_pkg;

    localparam logic [15:0] PORT_FE_MASK    = 16'h0001;
    localparam logic [15:0] PORT_FE_MATCH   = 16'h0000;
    localparam logic [15:0] PORT_7FFD_MASK  = 16'hC002;
    localparam logic [15:0] PORT_7FFD_MATCH = 16'h4000;
    localparam logic [15:0] PORT_1FFD_MASK  = 16'hF002;
    localparam logic [15:0] PORT_1FFD_MATCH = 16'h1000;

    localparam logic [2:0] BANK_SCREEN = 3'd5;
    localparam logic [2:0] BANK_MID    = 3'd2;

    // Bank for one 16K segment in +3 special mode (mode = 1FFD[2:1]).
    function automatic logic [2:0] special_bank(input logic [1:0] mode,
                                                input logic [1:0] segment);
        logic [2:0] bank;
        case (mode)
            2'b00:   bank = {1'b0, segment};
            2'b01:   bank = {1'b1, segment};
            2'b10: begin
                case (segment)
                    2'b00:   bank = 3'd4;
                    2'b01:   bank = 3'd5;
                    2'b10:   bank = 3'd6;
                    2'b11:   bank = 3'd3;
                    default: bank = 3'd0;
                endcase
            end
            2'b11: begin
                case (segment)
                    2'b00:   bank = 3'd4;
                    2'b01:   bank = 3'd7;
                    2'b10:   bank = 3'd6;
                    2'b11:   bank = 3'd3;
                    default: bank = 3'd0;
                endcase
            end
            default: bank = 3'd0;
        endcase
        return bank;
    endfunction

endpackage

// File: rtl/zx_int_gen.sv
// Frame interrupt generator: falling edge of registered nvblank starts a
// fixed-length active-low nINT pulse; edges during a pulse are ignored.
module zx_int_gen
    import zx_pkg::*;
#(
    parameter int INT_CYCLES = 228
) (
    input  logic clock_25,
    input  logic RESET_N,
    input  logic nvblank,
    output logic nINT
);

    localparam int CW = $clog2(INT_CYCLES + 1);

    logic          r_vb1;
    logic          r_vb2;
    logic [CW-1:0] r_cnt;
    logic          r_nint;
    logic          w_fall;

    assign w_fall = r_vb2 & ~r_vb1;
    assign nINT   = r_nint;

    // Synchroniser/edge history, pulse down-counter and registered nINT.
    always_ff @(posedge clock_25) begin
        if (!RESET_N) begin
            r_vb1  <= 1'b1;
            r_vb2  <= 1'b1;
            r_cnt  <= {CW{1'b0}};
            r_nint <= 1'b1;
        end else begin
            r_vb1 <= nvblank;
            r_vb2 <= r_vb1;
            if (w_fall && (r_cnt == {CW{1'b0}})) begin
                r_cnt  <= CW'(INT_CYCLES);
                r_nint <= 1'b0;
            end else if (r_cnt != {CW{1'b0}}) begin
                r_cnt  <= r_cnt - CW'(1);
                r_nint <= (r_cnt == CW'(1));
            end else begin
                r_nint <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/zx_pager.sv
// ZX Spectrum memory pager and system-port controller (128K..512K RAM).
// Optional +3 special paging via port 1FFD when ZX_PLUS3_PAGING_EN is defined.
module zx_pager
    import zx_pkg::*;
#(
    parameter int BANK_BITS  = 3,
    parameter int INT_CYCLES = 228
) (
    input  logic                    clock_25,
    input  logic                    RESET_N,
    input  logic [15:0]             A,
    input  logic [7:0]              D,
    input  logic                    nIORQ,
    input  logic                    nMREQ,
    input  logic                    nRD,
    input  logic                    nWR,
    input  logic                    nvblank,
    output logic [BANK_BITS+13:0]   mem_addr,
    output logic [15:0]             rom_addr,
    output logic                    rom_sel,
    output logic                    mem_we,
    output logic                    screen_sel,
    output logic [2:0]              border,
    output logic                    speaker,
    output logic                    paging_locked,
    output logic                    nINT
);

    logic                 w_io_wr;
    logic                 r_io_wr;
    logic                 w_io_fire;
    logic                 w_sel_fe;
    logic                 w_sel_7ffd;
    logic [7:0]           r_p7ffd;
    logic [2:0]           r_border;
    logic                 r_speaker;
    logic [4:0]           w_norm_bank;
    logic                 w_norm_rom;
    logic [4:0]           w_bank5;
    logic [BANK_BITS-1:0] w_bank;
    logic                 w_rom_sel;
    logic                 w_rom_hi;
    logic                 w_rombank_lo;

`ifdef ZX_PLUS3_PAGING_EN
    logic                 w_sel_1ffd;
    logic [2:0]           r_p1ffd;
    assign w_sel_1ffd = ((A & PORT_1FFD_MASK) == PORT_1FFD_MATCH);
`endif

    assign w_io_wr    = ~nIORQ & ~nWR & nRD;
    assign w_io_fire  = w_io_wr & ~r_io_wr;
    assign w_sel_fe   = ((A & PORT_FE_MASK) == PORT_FE_MATCH);
    assign w_sel_7ffd = ((A & PORT_7FFD_MASK) == PORT_7FFD_MATCH);

    // Write-strobe history plus the ULA port (border / beeper).
    always_ff @(posedge clock_25) begin
        if (!RESET_N) begin
            r_io_wr   <= 1'b0;
            r_border  <= 3'd0;
            r_speaker <= 1'b0;
        end else begin
            r_io_wr <= w_io_wr;
            if (w_io_fire && w_sel_fe) begin
                r_border  <= D[2:0];
                r_speaker <= D[4] ^ D[3];
            end
        end
    end

    // Paging registers; once 7FFD bit 5 is set they freeze until reset.
    always_ff @(posedge clock_25) begin
        if (!RESET_N) begin
            r_p7ffd <= 8'd0;
`ifdef ZX_PLUS3_PAGING_EN
            r_p1ffd <= 3'd0;
`endif
        end else begin
            if (w_io_fire && w_sel_7ffd && !r_p7ffd[5]) begin
                r_p7ffd <= D;
            end
`ifdef ZX_PLUS3_PAGING_EN
            if (w_io_fire && w_sel_1ffd && !r_p7ffd[5]) begin
                r_p1ffd <= D[2:0];
            end
`endif
        end
    end

    // Standard 128K-style map; the top segment takes Pentagon high bits.
    always_comb begin
        w_norm_bank = 5'd0;
        w_norm_rom  = 1'b0;
        case (A[15:14])
            2'b00: begin
                w_norm_bank = 5'd0;
                w_norm_rom  = 1'b1;
            end
            2'b01:   w_norm_bank = {2'b00, BANK_SCREEN};
            2'b10:   w_norm_bank = {2'b00, BANK_MID};
            2'b11:   w_norm_bank = {r_p7ffd[7:6], r_p7ffd[2:0]};
            default: w_norm_bank = 5'd0;
        endcase
    end

    // Final bank / ROM selection, with the +3 all-RAM override when built in.
    always_comb begin
        w_rombank_lo = r_p7ffd[4] | r_p7ffd[5];
`ifdef ZX_PLUS3_PAGING_EN
        w_rom_hi = r_p1ffd[2];
        if (r_p1ffd[0]) begin
            w_bank5   = {2'b00, special_bank(r_p1ffd[2:1], A[15:14])};
            w_rom_sel = 1'b0;
        end else begin
            w_bank5   = w_norm_bank;
            w_rom_sel = w_norm_rom;
        end
`else
        w_rom_hi  = 1'b0;
        w_bank5   = w_norm_bank;
        w_rom_sel = w_norm_rom;
`endif
    end

    // High bank bits beyond BANK_BITS are dropped by the cast.
    assign w_bank        = BANK_BITS'(w_bank5);
    assign mem_addr      = {w_bank, A[13:0]};
    assign rom_addr      = {w_rom_hi, w_rombank_lo, A[13:0]};
    assign rom_sel       = w_rom_sel;
    assign mem_we        = ~nMREQ & ~nWR & nRD & ~w_rom_sel;
    assign screen_sel    = r_p7ffd[3];
    assign paging_locked = r_p7ffd[5];
    assign border        = r_border;
    assign speaker       = r_speaker;

    zx_int_gen #(
        .INT_CYCLES (INT_CYCLES)
    ) u_int_gen (
        .clock_25 (clock_25),
        .RESET_N  (RESET_N),
        .nvblank  (nvblank),
        .nINT     (nINT)
    );

endmodule

// File: tb/tb_zx_pager.sv
// Directed self-checking bench for zx_pager (128K and 512K instances).
module tb_zx_pager;

    logic        clock_25 = 1'b0;
    logic        RESET_N;
    logic [15:0] A;
    logic [7:0]  D;
    logic        nIORQ, nMREQ, nRD, nWR, nvblank;

    logic [16:0] mem_addr;
    logic [15:0] rom_addr;
    logic        rom_sel, mem_we, screen_sel, speaker, paging_locked, nINT;
    logic [2:0]  border;

    logic [18:0] mem_addr5;
    logic [15:0] rom_addr5;
    logic        rom_sel5, mem_we5, screen_sel5, speaker5, paging_locked5, nINT5;
    logic [2:0]  border5;

    int n_checks = 0;
    int n_fail   = 0;

    always #20 clock_25 = ~clock_25;

    zx_pager #(.BANK_BITS(3), .INT_CYCLES(228)) dut (
        .clock_25(clock_25), .RESET_N(RESET_N), .A(A), .D(D),
        .nIORQ(nIORQ), .nMREQ(nMREQ), .nRD(nRD), .nWR(nWR), .nvblank(nvblank),
        .mem_addr(mem_addr), .rom_addr(rom_addr), .rom_sel(rom_sel),
        .mem_we(mem_we), .screen_sel(screen_sel), .border(border),
        .speaker(speaker), .paging_locked(paging_locked), .nINT(nINT)
    );

    zx_pager #(.BANK_BITS(5), .INT_CYCLES(228)) dut5 (
        .clock_25(clock_25), .RESET_N(RESET_N), .A(A), .D(D),
        .nIORQ(nIORQ), .nMREQ(nMREQ), .nRD(nRD), .nWR(nWR), .nvblank(nvblank),
        .mem_addr(mem_addr5), .rom_addr(rom_addr5), .rom_sel(rom_sel5),
        .mem_we(mem_we5), .screen_sel(screen_sel5), .border(border5),
        .speaker(speaker5), .paging_locked(paging_locked5), .nINT(nINT5)
    );

    typedef struct {
        logic [15:0] a;
        logic        wr;
        logic [16:0] mem;
        logic [15:0] rom;
        logic        rsel;
        logic        we;
    } vec_t;

    vec_t tbl [6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock_25);
        #1;
    endtask

    task automatic bus_idle();
        nIORQ = 1'b1; nMREQ = 1'b1; nRD = 1'b1; nWR = 1'b1;
    endtask

    task automatic io_out(input logic [15:0] port, input logic [7:0] val);
        A = port; D = val; nIORQ = 1'b0; nWR = 1'b0;
        tick();
        nIORQ = 1'b1; nWR = 1'b1;
        tick();
    endtask

    task automatic do_reset();
        RESET_N = 1'b0;
        bus_idle();
        nvblank = 1'b1;
        A = 16'h0000; D = 8'h00;
        tick(); tick(); tick();
        RESET_N = 1'b1;
        tick();
    endtask

    initial begin
        int low_cnt;

        tbl[0] = '{16'h0005, 1'b0, 17'h00000, 16'h4005, 1'b1, 1'b0};
        tbl[1] = '{16'h0005, 1'b1, 17'h00000, 16'h4005, 1'b1, 1'b0};
        tbl[2] = '{16'h4123, 1'b1, 17'h14123, 16'h4123, 1'b0, 1'b1};
        tbl[3] = '{16'h8000, 1'b0, 17'h08000, 16'h4000, 1'b0, 1'b0};
        tbl[4] = '{16'hC001, 1'b1, 17'h0C001, 16'h4001, 1'b0, 1'b1};
        tbl[5] = '{16'hFFFF, 1'b0, 17'h0FFFF, 16'h7FFF, 1'b0, 1'b0};

        do_reset();
        A = 16'hC000; #1;
        chk("rst_mem_c000", 32'(mem_addr), 32'h0);
        chk("rst_mem5_c000", 32'(mem_addr5), 32'h0);
        chk("rst_rom_sel", 32'(rom_sel), 32'h0);
        chk("rst_nint", 32'(nINT), 32'h1);
        chk("rst_border", 32'(border), 32'h0);
        chk("rst_screen", 32'(screen_sel), 32'h0);
        chk("rst_locked", 32'(paging_locked), 32'h0);
        A = 16'h0000; #1;
        chk("rst_rom_addr", 32'(rom_addr), 32'h0);

        io_out(16'h7FFD, 8'h13);
        chk("p13_screen", 32'(screen_sel), 32'h0);
        for (int i = 0; i < 6; i++) begin
            A = tbl[i].a; nMREQ = ~tbl[i].wr; nWR = ~tbl[i].wr; #1;
            chk($sformatf("vec%0d_rom_sel", i), 32'(rom_sel), 32'(tbl[i].rsel));
            chk($sformatf("vec%0d_rom_addr", i), 32'(rom_addr), 32'(tbl[i].rom));
            chk($sformatf("vec%0d_mem_we", i), 32'(mem_we), 32'(tbl[i].we));
            if (!tbl[i].rsel)
                chk($sformatf("vec%0d_mem_addr", i), 32'(mem_addr), 32'(tbl[i].mem));
        end
        bus_idle();

        io_out(16'h7FFD, 8'hC2);
        A = 16'hC000; #1;
        chk("c2_mem5", 32'(mem_addr5), 32'h68000);
        chk("c2_mem3", 32'(mem_addr), 32'h08000);

        io_out(16'h7FFD, 8'h08);
        chk("p08_screen", 32'(screen_sel), 32'h1);

        io_out(16'h7FFD, 8'h20);
        io_out(16'h7FFD, 8'h07);
        A = 16'hC000; #1;
        chk("lock_locked", 32'(paging_locked), 32'h1);
        chk("lock_top_bank", 32'(mem_addr), 32'h0);
        chk("lock_screen", 32'(screen_sel), 32'h0);
        A = 16'h0000; #1;
        chk("lock_rom_addr", 32'(rom_addr), 32'h4000);

        // Port write held 10 cycles must latch once, on its first cycle
        A = 16'h00FE; D = 8'h15; nIORQ = 1'b0; nWR = 1'b0;
        tick();
        chk("fe_latency", 32'(border), 32'h5);
        D = 8'h00;
        for (int i = 0; i < 9; i++) tick();
        bus_idle();
        tick();
        chk("fe_hold_border", 32'(border), 32'h5);
        chk("fe_hold_speaker", 32'(speaker), 32'h1);
        io_out(16'h00FE, 8'h18);
        chk("fe18_border", 32'(border), 32'h0);
        chk("fe18_speaker", 32'(speaker), 32'h0);

        // Frame interrupt: 2-cycle latency, 228-cycle pulse, no retrigger
        nvblank = 1'b0;
        tick();
        chk("int_lat1", 32'(nINT), 32'h1);
        tick();
        chk("int_lat2", 32'(nINT), 32'h0);
        low_cnt = 1;
        for (int i = 0; i < 400; i++) begin
            if (low_cnt == 50) nvblank = 1'b1;
            if (low_cnt == 100) nvblank = 1'b0;
            tick();
            if (nINT == 1'b0) low_cnt++;
            else break;
        end
        chk("int_len", 32'(low_cnt), 32'd228);
        chk("int_end", 32'(nINT), 32'h1);
        nvblank = 1'b1;
        tick(); tick(); tick();
        chk("int_no_retrig", 32'(nINT), 32'h1);

        nvblank = 1'b0;
        tick(); tick(); tick();
        chk("int_rearm", 32'(nINT), 32'h0);
        RESET_N = 1'b0;
        tick();
        chk("int_rst_mid", 32'(nINT), 32'h1);
        RESET_N = 1'b1;
        nvblank = 1'b1;
        tick();

        // Write during reset is discarded
        RESET_N = 1'b0;
        A = 16'h00FE; D = 8'h07; nIORQ = 1'b0; nWR = 1'b0;
        tick();
        bus_idle();
        RESET_N = 1'b1;
        tick();
        chk("rst_wr_border", 32'(border), 32'h0);
        chk("rst_wr_locked", 32'(paging_locked), 32'h0);

`ifdef ZX_PLUS3_PAGING_EN
        io_out(16'h1FFD, 8'h07);
        A = 16'h0000; nMREQ = 1'b0; nWR = 1'b0; #1;
        chk("p3_rom_sel", 32'(rom_sel), 32'h0);
        chk("p3_we_0000", 32'(mem_we), 32'h1);
        chk("p3_seg0", 32'(mem_addr), 32'h10000);
        chk("p3_rom_hi", 32'(rom_addr), 32'h8000);
        bus_idle();
        A = 16'h4000; #1;
        chk("p3_seg1", 32'(mem_addr), 32'h1C000);
        A = 16'h8000; #1;
        chk("p3_seg2", 32'(mem_addr), 32'h18000);
        A = 16'hC000; #1;
        chk("p3_seg3", 32'(mem_addr), 32'h0C000);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
